pc_fetch: RTL
=============

// Module: pc_fetch
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for the MIPS32 core.
//  Drives pc_plus4_o into the 32-bit 2:1 next-PC mux (input a; branch target on b)
//  and consumes the mux output as next_pc_i on redirects.
//  Fetches one word at a time over a req/ack instruction-memory port and presents
//  instr/pc to the IF/ID boundary, honouring downstream stall and exceptions.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  EXC_VECTOR  32'h8000_0180  PC loaded on exc_i
// PORTS
//  clk           in   1   single core clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  next_pc_i     in   32  redirect target from next-PC mux; bits[1:0] ignored (forced 0)
//  redirect_i    in   1   taken branch/jump; next_pc_i valid this cycle
//  exc_i         in   1   exception; fetch restarts at EXC_VECTOR
//  stall_i       in   1   downstream cannot accept instr this cycle
//  imem_req_o    out  1   fetch request; held with stable address until ack
//  imem_addr_o   out  32  fetch address (= pc_q)
//  imem_ack_i    in   1   transaction completes in cycle with req&ack
//  imem_rdata_i  in   32  instruction word, valid with ack
//  imem_err_i    in   1   bus error, valid with ack
//  pc_o          out  32  PC of presented instruction
//  pc_plus4_o    out  32  pc_q+4, combinational, wraps mod 2^32
//  instr_o       out  32  presented instruction
//  instr_valid_o out  1   instr_o/pc_o valid
//  fetch_err_o   out  1   presented instruction faulted (instr_o = NOP)
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_q=RESET_PC, state=IDLE, imem_req_o=0, instr_o=0 (NOP),
//   pc_o=0, instr_valid_o=0, fetch_err_o=0. Reset mid-transaction drops it silently.
//  States: IDLE, REQ, HOLD, KILL. imem_req_o=1 only in REQ and KILL.
//  IDLE: -> REQ on first clock after reset release.
//  REQ, no ack: hold addr; instr_valid_o<=0 (bubble).
//  REQ, ack: instr_o<=rdata (0 if err), fetch_err_o<=err, pc_o<=pc_q,
//   instr_valid_o<=1, pc_q<=pc_q+4; stall_i=1 -> HOLD, else stay REQ.
//  HOLD: outputs frozen, no request; stall_i=0 -> REQ next cycle (new pc_q).
//  KILL: awaiting ack of a cancelled fetch; on ack data discarded, pc_q<=pend_pc, -> REQ.
//  Priority per cycle: exc_i > redirect_i > sequential advance.
//  exc_i/redirect_i target T = EXC_VECTOR or {next_pc_i[31:2],2'b00}:
//   IDLE/HOLD/REQ-with-ack: pc_q<=T, instr_valid_o<=0, -> REQ.
//   REQ without ack: pend_pc<=T, instr_valid_o<=0, -> KILL.
//   KILL: pend_pc<=T (newest wins); if ack same cycle, pc_q<=T, -> REQ.
//  Redirect overrides stall_i (presented instr squashed). Latency: redirect in cycle N
//   -> imem_addr_o=T with req in N+1 (zero-wait memory: instr_valid_o at N+2).
//  Error fetch does not halt; exc_i from downstream redirects.
//  Max throughput: one instr per 2 cycles (registered request after each ack).
// STRUCTURE
//  pc_fetch_pkg (shared include): state encodings, NOP=32'h0, RESET_PC/EXC_VECTOR defaults.
//  Single module, no sub-module; pc_q/pend_pc/state regs + one adder for pc_plus4_o.
// TESTING
//  Reset, zero-wait mem, stall_i=0 -> addrs 0,4,8; instr_valid_o pulses every 2nd cycle.
//  Ack delayed 3 cycles at addr 0x10 -> req/addr held 0x10 all cycles, no bubble-data.
//  stall_i=1 on ack of 0x20 for 4 cycles -> instr/pc frozen, no req; then req 0x24.
//  redirect_i, next_pc_i=0x103 while waiting ack of 0x8 -> KILL, data dropped, next addr 0x100.
//  exc_i with redirect_i same cycle -> next addr 0x8000_0180.
//  imem_err_i with ack at 0x40 -> fetch_err_o=1, instr_o=0, pc_o=0x40; mid-fetch rst_n=0 -> all outputs reset.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, NOP word and default PC vectors.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP                = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// PC register + one-word-at-a-time fetch sequencer feeding IF/ID; redirect -> req at T next cycle.
// Backpressure: stall_i on the ack cycle freezes the presented instr and stops requesting until released.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc_i,
  input  logic        redirect_i,
  input  logic        exc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        fetch_err_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         gap_q, gap_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pco_q, pco_d;
  logic         vld_q, vld_d;
  logic         err_q, err_d;

  logic         redir;
  logic [31:0]  tgt;
  logic         ack;

  // gap_q drops the request for one cycle after each accepted fetch
  assign imem_req_o    = ((state_q == ST_REQ) && !gap_q) || (state_q == ST_KILL);
  assign imem_addr_o   = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign pc_o          = pco_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = vld_q;
  assign fetch_err_o   = err_q;

  assign ack   = imem_req_o & imem_ack_i;
  assign redir = exc_i | redirect_i;
  assign tgt   = exc_i ? EXC_VECTOR : word_align(next_pc_i);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    gap_d     = 1'b0;
    instr_d   = instr_q;
    pco_d     = pco_q;
    vld_d     = vld_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redir) begin
          pc_d  = tgt;
          vld_d = 1'b0;
        end
      end

      ST_REQ: begin
        if (ack) begin
          if (redir) begin
            pc_d  = tgt;
            vld_d = 1'b0;
          end else begin
            instr_d = imem_err_i ? NOP : imem_rdata_i;
            err_d   = imem_err_i;
            pco_d   = pc_q;
            vld_d   = 1'b1;
            pc_d    = pc_plus4_o;
            if (stall_i) state_d = ST_HOLD;
            else         gap_d   = 1'b1;
          end
        end else begin
          vld_d = 1'b0;
          if (redir) begin
            // Nothing is outstanding during the post-ack gap, so retarget directly
            if (gap_q) begin
              pc_d = tgt;
            end else begin
              pend_pc_d = tgt;
              state_d   = ST_KILL;
            end
          end
        end
      end

      ST_HOLD: begin
        if (redir) begin
          pc_d    = tgt;
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end else if (!stall_i) begin
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end
      end

      ST_KILL: begin
        vld_d = 1'b0;
        if (redir) pend_pc_d = tgt;
        if (ack) begin
          pc_d    = redir ? tgt : pend_pc_q;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      gap_q     <= 1'b0;
      instr_q   <= NOP;
      pco_q     <= 32'h0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      gap_q     <= gap_d;
      instr_q   <= instr_d;
      pco_q     <= pco_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

endmodule
